// File: rtl/mtm_alu_pkg.sv
// Shared constants, types and helpers for the MTM ALU serial deserializer.
// Optional feature macro: MTM_ALU_CRC_CHECK_EN (enables CRC-4 command check).
package mtm_alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CRC_W    = 4;
  localparam int unsigned ERR_W    = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BITCNT_W = 3;
  localparam int unsigned SR_W     = 2 * DATA_W;
  localparam int unsigned CRC_IN_W = SR_W + 1 + OP_W;

  // Opmodes
  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB = 3'b101;

  // Frame-type bit values
  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CTL  = 1'b1;

  // err_flags bit positions: {ERR_DATA, ERR_CRC, ERR_OP}
  localparam int unsigned ERR_DATA_BIT = 2;
  localparam int unsigned ERR_CRC_BIT  = 1;
  localparam int unsigned ERR_OP_BIT   = 0;

  // Data frames making up one command, and the saturation value of the counter
  localparam logic [CNT_W-1:0] DATA_FRAMES = 4'd8;
  localparam logic [CNT_W-1:0] DATA_SAT    = 4'd9;

  // Frame receiver states
  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_TYPE    = 2'd1,
    RX_PAYLOAD = 2'd2,
    RX_STOP    = 2'd3
  } rx_state_t;

  // CRC-4, poly x^4+x+1, init 0, input consumed MSB first
  function automatic logic [CRC_W-1:0] crc4(input logic [CRC_IN_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  // True for the four supported opmodes
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver: start, type, 8 payload bits MSB first, stop.
// frame_ok_c/frame_err_c are combinational strobes valid while the stop bit is sampled;
// rx_byte and is_ctl are stable registers during that cycle.
module mtm_alu_frame_rx
  import mtm_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              is_ctl,
  output logic              frame_ok_c,
  output logic              frame_err_c
);

  rx_state_t            state, state_nxt;
  logic [BITCNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]    byte_nxt;
  logic                 ctl_nxt;

  // State, bit counter, payload and type registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      rx_byte <= '0;
      is_ctl  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      rx_byte <= byte_nxt;
      is_ctl  <= ctl_nxt;
    end
  end

  // Next-state and frame strobes
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    byte_nxt    = rx_byte;
    ctl_nxt     = is_ctl;
    frame_ok_c  = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!sin) state_nxt = RX_TYPE;
      end
      RX_TYPE: begin
        ctl_nxt     = (sin == FRAME_CTL);
        bit_cnt_nxt = '0;
        state_nxt   = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        byte_nxt    = {rx_byte[BYTE_W-2:0], sin};
        bit_cnt_nxt = BITCNT_W'(bit_cnt + 3'd1);
        if (bit_cnt == 3'd7) state_nxt = RX_STOP;
      end
      RX_STOP: begin
        state_nxt = RX_IDLE;
        if (sin) frame_ok_c  = 1'b1;
        else     frame_err_c = 1'b1;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// MTM ALU command deserializer: assembles 8 DATA frames and one CTL frame into
// operands A/B and an opmode, with data-count, CRC and opmode checks.
// Optional feature macro: MTM_ALU_CRC_CHECK_EN (CRC-4 check; without it the CRC field is ignored).
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic              valid,
  output logic [ERR_W-1:0]  err_flags
);

  logic [BYTE_W-1:0] rx_byte;
  logic              is_ctl;
  logic              frame_ok_c;
  logic              frame_err_c;

  logic [SR_W-1:0]   data_sr, sr_nxt;
  logic [CNT_W-1:0]  data_cnt, cnt_nxt;
  logic [DATA_W-1:0] a_nxt, b_nxt;
  logic [OP_W-1:0]   op_nxt;
  logic              valid_nxt;
  logic [ERR_W-1:0]  err_nxt;

  logic [OP_W-1:0]   cmd_op;
  logic              crc_bad;

  mtm_alu_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .rx_byte    (rx_byte),
    .is_ctl     (is_ctl),
    .frame_ok_c (frame_ok_c),
    .frame_err_c(frame_err_c)
  );

  assign cmd_op = rx_byte[6:4];

`ifdef MTM_ALU_CRC_CHECK_EN
  // CRC over {B, A, 1, OP}; B sits in the upper half of the shift register
  assign crc_bad = (crc4({data_sr, 1'b1, cmd_op}) != rx_byte[CRC_W-1:0]);
`else
  assign crc_bad = 1'b0;
`endif

  // Command assembly and CTL-frame checks
  always_comb begin
    sr_nxt    = data_sr;
    cnt_nxt   = data_cnt;
    a_nxt     = a_out;
    b_nxt     = b_out;
    op_nxt    = op_out;
    valid_nxt = 1'b0;
    err_nxt   = '0;
    if (frame_err_c) begin
      sr_nxt  = '0;
      cnt_nxt = '0;
    end else if (frame_ok_c && !is_ctl) begin
      sr_nxt = {data_sr[SR_W-BYTE_W-1:0], rx_byte};
      if (data_cnt != DATA_SAT) cnt_nxt = CNT_W'(data_cnt + 4'd1);
    end else if (frame_ok_c && is_ctl) begin
      sr_nxt  = '0;
      cnt_nxt = '0;
      if (data_cnt != DATA_FRAMES) begin
        err_nxt[ERR_DATA_BIT] = 1'b1;
      end else if (crc_bad) begin
        err_nxt[ERR_CRC_BIT] = 1'b1;
      end else if (!op_is_legal(cmd_op)) begin
        err_nxt[ERR_OP_BIT] = 1'b1;
      end else begin
        b_nxt     = data_sr[SR_W-1:DATA_W];
        a_nxt     = data_sr[DATA_W-1:0];
        op_nxt    = cmd_op;
        valid_nxt = 1'b1;
      end
    end
  end

  // Command and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sr   <= '0;
      data_cnt  <= '0;
      a_out     <= '0;
      b_out     <= '0;
      op_out    <= '0;
      valid     <= 1'b0;
      err_flags <= '0;
    end else begin
      data_sr   <= sr_nxt;
      data_cnt  <= cnt_nxt;
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      op_out    <= op_nxt;
      valid     <= valid_nxt;
      err_flags <= err_nxt;
    end
  end

endmodule
